uart_console: RTL and testbench

//   Memory-mapped console device: the SoC-side endpoint of the simulation UART that SimTop exposes
//   (io_uart_out_valid/ch, io_uart_in_valid/ch). Accepts core load/store requests on a simple

---
 rtl/uart_console_if.sv | 23 ++
 rtl/uart_console.sv | 157 +++++++++++++++
 tb/tb_uart_console.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_console_if.sv
// Core-side MMIO bus of the console device: valid/ready request, one-cycle response pulse.
interface uart_console_if #(
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/uart_console.sv
// Console device: MMIO bus endpoint that queues TX chars for the harness UART and
// fetches RX chars from it on demand.
//
// state  | meaning
// S_IDLE | pops the FIFO head whenever one is queued
// S_GAP  | idle spacing after an emitted char, gap_cnt counts down to 1
module uart_console #(
  parameter int TX_DEPTH = 8,
  parameter int TX_GAP   = 0,
  parameter int ADDR_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  uart_console_if.slave      bus,
  output logic               uart_out_valid,
  output logic [7:0]         uart_out_ch,
  output logic               uart_in_valid,
  input  logic [7:0]         uart_in_ch
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int GAP_W = (TX_GAP < 2) ? 1 : $clog2(TX_GAP + 1);

  localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8);

  localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(TX_DEPTH);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(TX_GAP);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_GAP  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  logic [7:0]     mem [TX_DEPTH];
  logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0] tx_count;
  logic           tx_empty, tx_full;

  logic is_txdata, is_rxdata, is_status;
  logic accept, push, pop;

  logic        resp_valid_q, resp_err_q, err_d;
  logic [63:0] resp_rdata_q, rdata_d;

  logic unused_wdata;
  assign unused_wdata = ^bus.req_wdata[63:8];

  // Full-width compares also reject misaligned offsets.
  assign is_txdata = (bus.req_addr == A_TXDATA);
  assign is_rxdata = (bus.req_addr == A_RXDATA);
  assign is_status = (bus.req_addr == A_STATUS);

  assign tx_count = wr_ptr_q - rd_ptr_q;
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == CNT_FULL);

  // Only a TXDATA store into a full FIFO stalls; a same-cycle pop does not help.
  assign bus.req_ready = ~(tx_full & bus.req_wen & is_txdata);
  assign accept        = bus.req_valid & bus.req_ready;
  assign push          = accept & bus.req_wen & is_txdata;
  assign uart_in_valid = accept & ~bus.req_wen & is_rxdata;

  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (is_rxdata) begin
      if (!bus.req_wen) rdata_d = {56'b0, uart_in_ch};
    end else if (is_status) begin
      if (!bus.req_wen) rdata_d = {48'b0, 8'(tx_count), 6'b0, tx_full, tx_empty};
    end else if (!is_txdata) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= accept;
      if (accept) begin
        resp_rdata_q <= rdata_d;
        resp_err_q   <= err_d;
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q[PTR_W-1:0]] <= bus.req_wdata[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          pop = 1'b1;
          if (TX_GAP != 0) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_ONE;
        if (gap_cnt_q == GAP_ONE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Char is registered so the harness sees a clean one-cycle pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      uart_out_valid <= 1'b0;
      uart_out_ch    <= '0;
    end else begin
      uart_out_valid <= pop;
      if (pop) uart_out_ch <= mem[rd_ptr_q[PTR_W-1:0]];
    end
  end

endmodule

// File: tb/tb_uart_console.sv
// Directed bench for uart_console: three instances (TX_GAP 0, 15, 4) exercised in turn.
module tb_uart_console;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [1:0]  sel;
  logic        req_valid, req_wen;
  logic [3:0]  req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  uart_in_ch;

  logic [2:0]  out_valid, in_valid;
  logic [7:0]  out_ch0, out_ch1, out_ch2;

  logic        m_ready, m_rv, m_err;
  logic [63:0] m_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;

  uart_console_if #(.ADDR_W(4)) bus0 ();
  uart_console_if #(.ADDR_W(4)) bus1 ();
  uart_console_if #(.ADDR_W(4)) bus2 ();

  assign bus0.req_valid = req_valid && (sel == 2'd0);
  assign bus1.req_valid = req_valid && (sel == 2'd1);
  assign bus2.req_valid = req_valid && (sel == 2'd2);
  assign bus0.req_wen = req_wen;   assign bus1.req_wen = req_wen;   assign bus2.req_wen = req_wen;
  assign bus0.req_addr = req_addr; assign bus1.req_addr = req_addr; assign bus2.req_addr = req_addr;
  assign bus0.req_wdata = req_wdata; assign bus1.req_wdata = req_wdata; assign bus2.req_wdata = req_wdata;

  uart_console #(.TX_DEPTH(8), .TX_GAP(0), .ADDR_W(4)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0),
    .uart_out_valid(out_valid[0]), .uart_out_ch(out_ch0),
    .uart_in_valid(in_valid[0]), .uart_in_ch(uart_in_ch));
  uart_console #(.TX_DEPTH(8), .TX_GAP(15), .ADDR_W(4)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1),
    .uart_out_valid(out_valid[1]), .uart_out_ch(out_ch1),
    .uart_in_valid(in_valid[1]), .uart_in_ch(uart_in_ch));
  uart_console #(.TX_DEPTH(8), .TX_GAP(4), .ADDR_W(4)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2),
    .uart_out_valid(out_valid[2]), .uart_out_ch(out_ch2),
    .uart_in_valid(in_valid[2]), .uart_in_ch(uart_in_ch));

  always_comb begin
    m_ready = bus0.req_ready; m_rv = bus0.resp_valid;
    m_rdata = bus0.resp_rdata; m_err = bus0.resp_err;
    if (sel == 2'd1) begin
      m_ready = bus1.req_ready; m_rv = bus1.resp_valid;
      m_rdata = bus1.resp_rdata; m_err = bus1.resp_err;
    end else if (sel == 2'd2) begin
      m_ready = bus2.req_ready; m_rv = bus2.resp_valid;
      m_rdata = bus2.resp_rdata; m_err = bus2.resp_err;
    end
  end

  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0]  ch1 [16];
  int unsigned t1  [16];
  int n1 = 0;
  int n2 = 0;
  always @(negedge clock) begin
    if (out_valid[1] && n1 < 16) begin
      ch1[n1] <= out_ch1;
      t1[n1]  <= cyc;
      n1      <= n1 + 1;
    end
    if (out_valid[2]) n2 <= n2 + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One accepted request; on return the response cycle is visible.
  task automatic access(input logic wen, input logic [3:0] addr, input logic [63:0] wdata);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    #1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    int pushed;
    int stall_at;
    int found;
    int snap;

    reset = 1'b0; sel = 2'd0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    uart_in_ch = 8'h00;

    // 1: reset state
    repeat (3) tick();
    check("rst_out_valid", {61'b0, out_valid}, 64'h0);
    check("rst_resp_valid", {63'b0, m_rv}, 64'h0);
    reset = 1'b1;
    tick();
    check("idle_ready", {63'b0, m_ready}, 64'h1);
    check("idle_rdata", m_rdata, 64'h0);
    check("idle_err", {63'b0, m_err}, 64'h0);
    check("idle_in_valid", {61'b0, in_valid}, 64'h0);
    access(1'b0, 4'h8, 64'h0);
    check("status0_valid", {63'b0, m_rv}, 64'h1);
    check("status0_rdata", m_rdata, 64'h1);
    check("status0_err", {63'b0, m_err}, 64'h0);
    tick();
    check("resp_one_cycle", {63'b0, m_rv}, 64'h0);
    check("rdata_hold", m_rdata, 64'h1);

    // 2: TX latency with TX_GAP=0
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 4'h0; req_wdata = 64'hAB48;
    #1;
    check("tx_ready", {63'b0, m_ready}, 64'h1);
    tick();
    req_valid = 1'b0;
    check("tx_resp_valid", {63'b0, m_rv}, 64'h1);
    check("tx_resp_err", {63'b0, m_err}, 64'h0);
    check("tx_out_t1", {63'b0, out_valid[0]}, 64'h0);
    tick();
    check("tx_out_t2", {63'b0, out_valid[0]}, 64'h1);
    check("tx_ch_t2", {56'b0, out_ch0}, 64'h48);
    tick();
    check("tx_out_t3", {63'b0, out_valid[0]}, 64'h0);
    check("tx_ch_hold", {56'b0, out_ch0}, 64'h48);

    // 4: RX fetch
    uart_in_ch = 8'h61;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 4'h4;
    #1;
    check("rx_strobe", {63'b0, in_valid[0]}, 64'h1);
    tick();
    req_valid = 1'b0;
    #1;
    check("rx_strobe_off", {63'b0, in_valid[0]}, 64'h0);
    check("rx_rdata_61", m_rdata, 64'h61);
    uart_in_ch = 8'hFF;
    access(1'b0, 4'h4, 64'h0);
    check("rx_rdata_ff", m_rdata, 64'hFF);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 4'h4; req_wdata = 64'h77;
    #1;
    check("rx_store_no_strobe", {63'b0, in_valid[0]}, 64'h0);
    tick();
    req_valid = 1'b0;
    check("rx_store_err", {63'b0, m_err}, 64'h0);
    check("rx_store_rdata", m_rdata, 64'h0);

    // 5: bad offsets
    access(1'b0, 4'hC, 64'h0);
    check("bad_load_err", {63'b0, m_err}, 64'h1);
    check("bad_load_rdata", m_rdata, 64'h0);
    access(1'b1, 4'h2, 64'h55);
    check("bad_store_err", {63'b0, m_err}, 64'h1);
    repeat (3) tick();
    access(1'b0, 4'h8, 64'h0);
    check("bad_store_status", m_rdata, 64'h1);
    check("status_err", {63'b0, m_err}, 64'h0);

    // 3: TX_GAP=15 backpressure and spacing
    sel = 2'd1;
    pushed = 0; stall_at = -1;
    for (int k = 0; k < 200 && pushed < 10; k++) begin
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 4'h0; req_wdata = 64'(8'h30 + pushed);
      #1;
      if (m_ready) begin
        tick();
        pushed++;
      end else if (stall_at < 0) begin
        stall_at = pushed;
        req_wen = 1'b0; req_addr = 4'h8;
        #1;
        tick();
        check("full_status", m_rdata, 64'h802);
      end else begin
        tick();
      end
    end
    req_valid = 1'b0;
    check("all_pushed", 64'(pushed), 64'd10);
    check("stall_point", 64'(stall_at), 64'd9);
    repeat (200) tick();
    check("emit_count", 64'(n1), 64'd10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("emit_ch%0d", i), {56'b0, ch1[i]}, 64'(8'h30 + i));
      if (i > 0) check($sformatf("emit_gap%0d", i), 64'(t1[i] - t1[i-1]), 64'd16);
    end
    access(1'b0, 4'h8, 64'h0);
    check("drained_status", m_rdata, 64'h1);

    // 6: reset mid-drain
    sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 4'h0; req_wdata = 64'(8'h41 + i);
      #1;
      tick();
    end
    req_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      if (out_valid[2]) found = 1;
      else tick();
    end
    check("drain_started", 64'(found), 64'd1);
    reset = 1'b0;
    #1;
    check("rst_drops_out", {63'b0, out_valid[2]}, 64'h0);
    check("rst_clears_ch", {56'b0, out_ch2}, 64'h0);
    snap = n2;
    repeat (3) tick();
    reset = 1'b1;
    repeat (40) tick();
    check("no_emit_after_rst", 64'(n2), 64'(snap));
    access(1'b0, 4'h8, 64'h0);
    check("post_rst_status", m_rdata, 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
